// File: rtl/fir_sched.sv
// Round-robin scheduler sharing one 3-tap FIR datapath among NCH sample streams,
// with per-channel tap history, burst preemption and end-of-stream tail flush.

module fir_sched_hist #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift,
  input  logic          clr,
  input  logic [DW-1:0] x,
  output logic [DW-1:0] h1,
  output logic [DW-1:0] h2
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      h1 <= '0;
      h2 <= '0;
    end else if (shift) begin
      h2 <= h1;
      h1 <= x;
    end
  end
endmodule

module fir_sched #(
  parameter int NCH       = 2,
  parameter int DW        = 4,
  parameter int OW        = 9,
  parameter int C0        = 3,
  parameter int C1        = 4,
  parameter int C2        = 5,
  parameter int MAX_BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*DW-1:0]       in_data,
  input  logic [NCH-1:0]          in_last,
  output logic [NCH-1:0]          in_ready,
  output logic                    out_valid,
  output logic [OW-1:0]           out_data,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic                    done,
  output logic [$clog2(NCH)-1:0]  done_ch
);
  localparam int CW = $clog2(NCH);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {IDLE, STREAM, SWITCH, FLUSH, DONE} state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            g, rr_ptr, gnt_idx, g_inc;
  logic [BW-1:0]            bcnt;
  logic                     fcnt;
  logic                     req_any, acc, fire;
  logic [NCH-1:0][DW-1:0]   din, h1, h2;
  logic [DW-1:0]            x_eff;
  logic [OW-1:0]            y;

  assign din   = in_data;
  assign acc   = (state == STREAM) && in_valid[g];
  assign fire  = acc || (state == FLUSH);
  assign x_eff = (state == FLUSH) ? '0 : din[g];
  assign g_inc = (g == CW'(NCH - 1)) ? '0 : g + 1'b1;
  assign y     = OW'(C0) * OW'(x_eff) + OW'(C1) * OW'(h1[g]) + OW'(C2) * OW'(h2[g]);

  // First requester at or after rr_ptr, cyclic.
  always_comb begin
    int j;
    j       = 0;
    req_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      j = (int'(rr_ptr) + i) % NCH;
      if (!req_any && in_valid[j]) begin
        req_any = 1'b1;
        gnt_idx = CW'(j);
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_hist
    fir_sched_hist #(.DW(DW)) u_hist (
      .clk  (clk),
      .rst_n(rst_n),
      .shift(fire && (g == CW'(k))),
      .clr  ((state == DONE) && (g == CW'(k))),
      .x    (x_eff),
      .h1   (h1[k]),
      .h2   (h2[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (req_any) state_n = STREAM;
      // in_last takes priority over the burst limit.
      STREAM: if (acc) begin
                if (in_last[g])                     state_n = FLUSH;
                else if (bcnt == BW'(MAX_BURST - 1)) state_n = SWITCH;
              end
      SWITCH: state_n = IDLE;
      FLUSH:  if (fcnt) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (state == STREAM) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g         <= '0;
      rr_ptr    <= '0;
      bcnt      <= '0;
      fcnt      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      done      <= 1'b0;
      done_ch   <= '0;
    end else begin
      out_valid <= fire;
      done      <= (state == FLUSH) && fcnt;
      if (fire) begin
        out_data <= y;
        out_ch   <= g;
      end
      if ((state == FLUSH) && fcnt) done_ch <= g;
      if (state == IDLE && req_any) begin
        g    <= gnt_idx;
        bcnt <= '0;
      end
      if (acc) bcnt <= bcnt + 1'b1;
      if (state == STREAM) fcnt <= 1'b0;
      if (state == FLUSH)  fcnt <= 1'b1;
      if (state == SWITCH || state == DONE) rr_ptr <= g_inc;
    end
  end
endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: table vectors, directed multi-cycle sequences and a
// randomized run scored per channel against a convolution model.

module tb_fir_sched;
  localparam int NCH = 2, DW = 4, OW = 9, MB = 4;
  localparam int C0 = 3, C1 = 4, C2 = 5;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NCH-1:0]    in_valid, in_last, in_ready;
  logic [NCH*DW-1:0] in_data;
  logic              out_valid, done;
  logic [OW-1:0]     out_data;
  logic              out_ch, done_ch;

  fir_sched #(.NCH(NCH), .DW(DW), .OW(OW), .C0(C0), .C1(C1), .C2(C2), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .done(done), .done_ch(done_ch));

  always #5 clk = ~clk;

  typedef struct { int d; int last; int gap; } src_t;
  typedef struct { int cyc; int ch; int d; int last; } ev_t;
  typedef struct { int ch; int n; logic [3:0][3:0] s; int ne; logic [5:0][8:0] e; } vec_t;

  src_t src_q[NCH][$];
  int   exp_q[NCH][$];
  ev_t  ev_q[$], done_q[$], acc_q[$];
  int   cyc = 0, total = 0, bad = 0;
  int   onehot_bad = 0, run = 0, max_run = 0;
  logic [NCH-1:0] prev_ready = '0;
  vec_t vecs[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) ev_q.push_back('{cyc, int'(out_ch), int'(out_data), 0});
    if (done)      done_q.push_back('{cyc, int'(done_ch), 0, 0});
    if (!$onehot0(in_ready)) onehot_bad++;
    if (in_ready != '0 && prev_ready == '0) run = 0;
    for (int k = 0; k < NCH; k++)
      if (rst_n && in_valid[k] && in_ready[k]) begin
        acc_q.push_back('{cyc, k, int'(in_data[k*DW +: DW]), int'(in_last[k])});
        run++;
        if (run > max_run) max_run = run;
      end
    prev_ready = in_ready;
  end

  // Source driver: holds each sample until accepted; gap inserts idle cycles first.
  initial begin
    logic [NCH-1:0] acc;
    in_valid = '0; in_data = '0; in_last = '0;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      for (int k = 0; k < NCH; k++) begin
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        if (src_q[k].size() > 0) begin
          if (src_q[k][0].gap > 0) src_q[k][0].gap = src_q[k][0].gap - 1;
          else begin
            in_valid[k]          = 1'b1;
            in_data[k*DW +: DW]  = DW'(src_q[k][0].d);
            in_last[k]           = src_q[k][0].last[0];
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: one stream convolved with the taps, zero before start, two zero tail samples.
  task automatic add_stream(input int ch, input int xs[$], input int gaps[$]);
    int n = xs.size();
    for (int i = 0; i < n; i++) src_q[ch].push_back('{xs[i], (i == n - 1) ? 1 : 0, gaps[i]});
    for (int i = 0; i < n + 2; i++) begin
      int x0 = (i < n) ? xs[i] : 0;
      int x1 = (i >= 1 && i - 1 < n) ? xs[i-1] : 0;
      int x2 = (i >= 2 && i - 2 < n) ? xs[i-2] : 0;
      exp_q[ch].push_back(C0 * x0 + C1 * x1 + C2 * x2);
    end
  endtask

  task automatic score(input int e0);
    for (int i = e0; i < ev_q.size(); i++) begin
      int c = ev_q[i].ch;
      if (exp_q[c].size() == 0) check("score_extra_out", 1, 0);
      else check($sformatf("score_ch%0d_data", c), ev_q[i].d, exp_q[c].pop_front());
    end
    for (int k = 0; k < NCH; k++) check($sformatf("score_ch%0d_left", k), exp_q[k].size(), 0);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_q.size() < n && k < budget) begin @(negedge clk); k++; end
    check("wait_done", done_q.size(), n);
  endtask

  task automatic do_reset();
    for (int k = 0; k < NCH; k++) begin src_q[k].delete(); exp_q[k].delete(); end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int e0 = ev_q.size(), d0 = done_q.size(), a0 = acc_q.size(), ne;
    for (int i = 0; i < v.n; i++) src_q[v.ch].push_back('{int'(v.s[i]), (i == v.n - 1) ? 1 : 0, 0});
    wait_done(d0 + 1, 200);
    ne = ev_q.size() - e0;
    check({tag, "_count"}, ne, v.ne);
    for (int i = 0; i < ne && i < v.ne; i++) begin
      check({tag, "_data"}, ev_q[e0+i].d, int'(v.e[i]));
      check({tag, "_ch"}, ev_q[e0+i].ch, v.ch);
      if (i > 0) check({tag, "_consec"}, ev_q[e0+i].cyc - ev_q[e0+i-1].cyc, 1);
    end
    if (ne > 0 && done_q.size() > d0 && acc_q.size() > a0) begin
      check({tag, "_lat"}, ev_q[e0].cyc - acc_q[a0].cyc, 1);
      check({tag, "_done_ch"}, done_q[d0].ch, v.ch);
      check({tag, "_done_cyc"}, done_q[d0].cyc, ev_q[ev_q.size()-1].cyc);
      check({tag, "_done_after_last"}, done_q[d0].cyc - acc_q[acc_q.size()-1].cyc, 3);
    end
  endtask

  initial begin
    int xs[$], gs[$], e0, a0, d0, k;
    vecs[0] = '{ch:0, n:3, s:{4'd0, 4'd3, 4'd2, 4'd1}, ne:5,
                e:{9'd0, 9'd15, 9'd22, 9'd22, 9'd10, 9'd3}};
    vecs[1] = '{ch:1, n:4, s:{4'd15, 4'd15, 4'd15, 4'd15}, ne:6,
                e:{9'd75, 9'd135, 9'd180, 9'd180, 9'd105, 9'd45}};
    vecs[2] = '{ch:0, n:2, s:{4'd0, 4'd0, 4'd0, 4'd2}, ne:4,
                e:{9'd0, 9'd0, 9'd0, 9'd10, 9'd8, 9'd6}};
    vecs[3] = '{ch:1, n:1, s:{4'd0, 4'd0, 4'd0, 4'd1}, ne:3,
                e:{9'd0, 9'd0, 9'd0, 9'd5, 9'd4, 9'd3}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_out_data", int'(out_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Two channels contending with ramps: 4-sample bursts alternate, histories stay private.
    do_reset();
    e0 = ev_q.size(); a0 = acc_q.size(); d0 = done_q.size();
    xs = '{1, 2, 3, 4, 5, 6, 7, 8}; gs = '{0, 0, 0, 0, 0, 0, 0, 0};
    add_stream(0, xs, gs);
    xs = '{8, 9, 10, 11, 12, 13, 14, 15};
    add_stream(1, xs, gs);
    wait_done(d0 + 2, 300);
    score(e0);
    check("pre_acc_count", acc_q.size() - a0, 16);
    if (acc_q.size() - a0 == 16) begin
      for (int i = 0; i < 16; i++) check("pre_order", acc_q[a0+i].ch, (i / 4) % 2);
      check("pre_backtoback", acc_q[a0+1].cyc - acc_q[a0].cyc, 1);
      check("pre_switch_gap0", acc_q[a0+4].cyc - acc_q[a0+3].cyc, 3);
      check("pre_switch_gap1", acc_q[a0+8].cyc - acc_q[a0+7].cyc, 3);
      check("pre_done_gap", acc_q[a0+12].cyc - acc_q[a0+11].cyc, 5);
    end

    // Stall of 3 cycles before sample 3: no output in the gap, stalls not counted in the burst.
    e0 = ev_q.size(); a0 = acc_q.size(); d0 = done_q.size();
    xs = '{1, 2, 3, 4, 5}; gs = '{0, 0, 3, 0, 0};
    add_stream(0, xs, gs);
    wait_done(d0 + 1, 200);
    score(e0);
    check("stall_acc_count", acc_q.size() - a0, 5);
    if (acc_q.size() - a0 == 5) begin
      int quiet = 0;
      check("stall_gap", acc_q[a0+2].cyc - acc_q[a0+1].cyc, 4);
      check("stall_resume", acc_q[a0+3].cyc - acc_q[a0+2].cyc, 1);
      check("stall_preempt_regrant", acc_q[a0+4].cyc - acc_q[a0+3].cyc, 3);
      for (int i = e0; i < ev_q.size(); i++)
        if (ev_q[i].cyc > acc_q[a0+1].cyc + 1 && ev_q[i].cyc <= acc_q[a0+2].cyc) quiet++;
      check("stall_quiet", quiet, 0);
    end

    // Reset pulse during FLUSH discards the tail and the done pulse.
    xs = '{1, 2, 3}; gs = '{0, 0, 0};
    add_stream(0, xs, gs);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(in_valid[0] && in_ready[0] && in_last[0]) && k < 50);
    check("rf_reach_last", int'(k < 50), 1);
    @(posedge clk); #1;
    for (int c = 0; c < NCH; c++) begin src_q[c].delete(); exp_q[c].delete(); end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    e0 = ev_q.size(); d0 = done_q.size();
    @(negedge clk);
    check("rf_out_valid", int'(out_valid), 0);
    check("rf_out_data", int'(out_data), 0);
    check("rf_done", int'(done), 0);
    check("rf_in_ready", int'(in_ready), 0);
    repeat (6) @(negedge clk);
    check("rf_no_out", ev_q.size() - e0, 0);
    check("rf_no_done", done_q.size() - d0, 0);
    apply_vec(vecs[3], "vec3");

    // Randomized streams on both channels.
    do_reset();
    e0 = ev_q.size(); d0 = done_q.size();
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < NCH; c++) begin
        int n = $urandom_range(1, 10);
        xs.delete(); gs.delete();
        for (int i = 0; i < n; i++) begin
          xs.push_back($urandom_range(0, 15));
          gs.push_back(($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0);
        end
        add_stream(c, xs, gs);
      end
    wait_done(d0 + 6, 4000);
    score(e0);
    check("max_burst_run", int'(max_run <= MB), 1);
    check("in_ready_onehot0", onehot_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
